dco_coarse_tuner: RTL and testbench
===================================

# dco_coarse_tuner

Frequency-acquisition controller for the 128-code thermometer-controlled DCO. Runs a 7-step binary search over code index 0..127, then one verify measurement. Each step measures DCO edges over a fixed window of reference clocks and compares the count with a programmed target. It drives the DCO `coarse` bus and reports the final code, the measured count and lock status to the ADPLL top level.

## Interface
- `WIN`, 64: measurement window length, reference cycles.
- `SETTLE`, 4: reference cycles waited after each code change before measuring.
- `DRAIN`, 4: reference cycles after the window closes before the count is sampled (CDC settle).
- `CW`, 16: width of the DCO edge counter, target and measured count.
- `TOL`, 2: maximum |count − target| for lock.

Ports:
- `clk`  in  1  reference clock; FSM domain.
- `reset_`  in  1  reset, asynchronous, active-high; resets both clock domains.
- `dco_clk`  in  1  DCO output clock; counter domain.
- `start`  in  1  begin acquisition; sampled only in IDLE.
- `target`  in  CW  desired DCO edge count per window; captured at start.
- `coarse`  out  128  DCO control code, thermometer: low `code_idx` bits set.
- `code_idx`  out  7  current or final code index.
- `meas_count`  out  CW  last sampled DCO count.
- `busy`  out  1  high from start acceptance until done.
- `done`  out  1  one-cycle pulse at end of acquisition.
- `lock`  out  1  verify result; held until the next accepted start or reset.

## Operation
- Reset values: `coarse`=0, `code_idx`=0, `meas_count`=0, `busy`=0, `done`=0, `lock`=0. Internal state: FSM=IDLE, `gate`=0, DCO counter=0, synchronizers=0.
- `coarse` is a registered function of `code_idx`: bit k = (k < code_idx). Bit 127 is always 0.
- FSM states: IDLE, SETTLE, MEASURE, DRAIN, COMPARE, DONE.
- IDLE: on `start`=1, perform all of the following, then go to SETTLE:
  - capture `target`;
  - set `busy`=1 and `lock`=0;
  - set trial bit b=6 and `code_idx`=7'b1000000.
- SETTLE: wait SETTLE cycles, then MEASURE.
- MEASURE: hold `gate`=1 for WIN cycles, then go to DRAIN.
- DRAIN: hold `gate`=0 for DRAIN cycles, then sample the DCO counter into `meas_count` and go to COMPARE.
- DCO domain:
  - `gate` passes through a 2-flop synchronizer clocked by `dco_clk`.
  - The counter clears on the synchronized rising edge of `gate`.
  - The counter increments on each `dco_clk` rising edge while the synchronized gate is high.
  - The counter saturates at 2^CW−1.
  - The count is static during DRAIN, so no Gray coding is needed. DRAIN ≥ 2 is required.
- COMPARE, search step (b ≥ 0):
  - If `meas_count` ≤ target, keep bit b; otherwise clear it.
  - If b > 0: decrement b, set the new bit b in `code_idx`, go to SETTLE.
  - If b = 0: go to SETTLE for the verify pass with the final `code_idx`.
- COMPARE, verify pass:
  - `lock` = (|meas_count − target| ≤ TOL), computed unsigned with a CW+1-bit difference.
  - Go to DONE.
- DONE: `done`=1 for one cycle, `busy`=0, go to IDLE. `code_idx`, `coarse` and `meas_count` hold until the next start.
- Search result: the largest index whose count is ≤ target. If no index qualifies, the result is 0.
- `start` while busy is ignored. `start` held high in DONE is not accepted until IDLE.
- `reset_` mid-operation aborts immediately:
  - all outputs return to reset values;
  - `gate` drops and the counter clears.

## Timing
- Start edge to SETTLE entry: 1 cycle. `busy` is high the cycle after the start edge.
- Per step: SETTLE+WIN+DRAIN+1 cycles. 8 steps (7 search + verify).
- `done` asserts 8·(SETTLE+WIN+DRAIN+1)+1 cycles after the start edge. With defaults that is 585.
- `code_idx`/`coarse` change only on the cycle leaving COMPARE, and never during MEASURE.
- `lock` updates in the same cycle that FSM enters DONE, one cycle before `done`.
- The synchronizer costs 2 `dco_clk` edges at each gate boundary. This is identical for every step, so the comparison is unbiased.

## Test plan
- Linear DCO stub (edges per window = 100+2·idx), target=200 → after 585 cycles: `code_idx`=50, `coarse` low 50 bits set, `meas_count`=200, `lock`=1, single `done` pulse.
- Same stub, target=0 → `code_idx`=0, `coarse`=0, `meas_count`=100, `lock`=0.
- Same stub, target=16'hFFFF → `code_idx`=127, `coarse`=128'h7fff…f, `meas_count`=354, `lock`=0.
- Same stub, target=199 → `code_idx`=49, `meas_count`=198, `lock`=1 (diff 1 ≤ TOL); target=195 → `code_idx`=47, `meas_count`=194, `lock`=1.
- Pulse `start` at cycles 10 and 300 of a run → second pulse ignored, exactly one `done` at 585. Assert `reset_` during MEASURE of step 3 → all outputs 0 within the same cycle. A new `start` then completes normally.
- Real DCO behavioural model, 100 MHz `clk`, target=200 → `lock`=1 and `code_idx` monotonic-search trace matches the reference Python search. Saturation check with `CW`=8 and target=255 → counter pins at 255 with no wrap.

Source files
------------

// File: rtl/dco_coarse_tuner.sv
`timescale 1ns/1ps
// Coarse frequency acquisition for the 128-code thermometer DCO: 7-step binary
// search on the edge count per reference window, then one verify measurement.
module dco_coarse_tuner #(
    parameter int WIN    = 64,
    parameter int SETTLE = 4,
    parameter int DRAIN  = 4,
    parameter int CW     = 16,
    parameter int TOL    = 2
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic          dco_clk,
    input  logic          start,
    input  logic [CW-1:0] target,
    output logic [127:0]  coarse,
    output logic [6:0]    code_idx,
    output logic [CW-1:0] meas_count,
    output logic          busy,
    output logic          done,
    output logic          lock
);

    localparam int TW = $clog2(WIN + SETTLE + DRAIN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_DRAIN,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t        state_q, state_n;
    logic [TW-1:0] tmr_q, tmr_n;
    logic [2:0]    bit_q, bit_n;
    logic          verify_q, verify_n;
    logic [6:0]    code_n;
    logic [127:0]  coarse_n;
    logic [CW-1:0] meas_n;
    logic          busy_n, done_n, lock_n;
    logic          gate_q, gate_n;
    logic          tgt_load;
    logic [CW-1:0] tgt_q;

    logic          gate_sync_p0, gate_sync_p1, gate_sync_p2;
    logic [CW-1:0] dco_cnt;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    function automatic logic within_tol(input logic [CW-1:0] m, input logic [CW-1:0] t);
        logic [CW:0] d;
        if (m >= t) d = {1'b0, m} - {1'b0, t};
        else        d = {1'b0, t} - {1'b0, m};
        return d <= (CW+1)'(TOL);
    endfunction

    always_comb begin
        state_n  = state_q;
        tmr_n    = tmr_q;
        bit_n    = bit_q;
        verify_n = verify_q;
        code_n   = code_idx;
        meas_n   = meas_count;
        busy_n   = busy;
        done_n   = 1'b0;
        lock_n   = lock;
        tgt_load = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tgt_load = 1'b1;
                    busy_n   = 1'b1;
                    lock_n   = 1'b0;
                    bit_n    = 3'd6;
                    verify_n = 1'b0;
                    code_n   = 7'b1000000;
                    tmr_n    = '0;
                    state_n  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (tmr_q == TW'(SETTLE - 1)) begin
                    tmr_n   = '0;
                    state_n = S_MEASURE;
                end else begin
                    tmr_n = tmr_q + TW'(1);
                end
            end
            S_MEASURE: begin
                if (tmr_q == TW'(WIN - 1)) begin
                    tmr_n   = '0;
                    state_n = S_DRAIN;
                end else begin
                    tmr_n = tmr_q + TW'(1);
                end
            end
            S_DRAIN: begin
                // The DCO counter has been frozen for DRAIN cycles, so a plain
                // multi-bit sample is stable here.
                if (tmr_q == TW'(DRAIN - 1)) begin
                    tmr_n   = '0;
                    meas_n  = dco_cnt;
                    state_n = S_COMPARE;
                end else begin
                    tmr_n = tmr_q + TW'(1);
                end
            end
            S_COMPARE: begin
                if (!verify_q) begin
                    if (meas_count > tgt_q) code_n[bit_q] = 1'b0;
                    if (bit_q != 3'd0) begin
                        bit_n                 = bit_q - 3'd1;
                        code_n[bit_q - 3'd1]  = 1'b1;
                    end else begin
                        verify_n = 1'b1;
                    end
                    state_n = S_SETTLE;
                end else begin
                    lock_n  = within_tol(meas_count, tgt_q);
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        gate_n = (state_n == S_MEASURE);

        // coarse is registered alongside code_idx so both move on the same edge
        coarse_n = '0;
        for (int k = 0; k < 128; k++) begin
            coarse_n[k] = (7'(k) < code_n);
        end
    end

    // Reference-clock domain registers
    always_ff @(posedge clk or posedge reset_) begin
        if (reset_) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            bit_q      <= '0;
            verify_q   <= 1'b0;
            code_idx   <= '0;
            coarse     <= '0;
            meas_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            lock       <= 1'b0;
            gate_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            tmr_q      <= tmr_n;
            bit_q      <= bit_n;
            verify_q   <= verify_n;
            code_idx   <= code_n;
            coarse     <= coarse_n;
            meas_count <= meas_n;
            busy       <= busy_n;
            done       <= done_n;
            lock       <= lock_n;
            gate_q     <= gate_n;
        end
    end

    always_ff @(posedge clk) begin
        if (tgt_load) tgt_q <= target;
    end

    // DCO clock domain: gate synchronizer, edge detect, saturating counter
    always_ff @(posedge dco_clk or posedge reset_) begin
        if (reset_) begin
            gate_sync_p0 <= 1'b0;
            gate_sync_p1 <= 1'b0;
            gate_sync_p2 <= 1'b0;
            dco_cnt      <= '0;
        end else begin
            gate_sync_p0 <= gate_q;
            gate_sync_p1 <= gate_sync_p0;
            gate_sync_p2 <= gate_sync_p1;
            // The edge that sees the synchronized rise restarts the count at 1,
            // so every edge with the synchronized gate high is counted once.
            if (gate_sync_p1 && !gate_sync_p2) dco_cnt <= CW'(1);
            else if (gate_sync_p1)             dco_cnt <= sat_inc(dco_cnt);
        end
    end

endmodule

// File: tb/tb_dco_coarse_tuner.sv
`timescale 1ns/1ps
// Bench for dco_coarse_tuner: linear DCO stub (100+2*idx edges per window) and
// a fast fixed clock on a CW=8 instance for counter saturation.
module tb_dco_coarse_tuner;

    logic          clk = 1'b0;
    logic          reset_ = 1'b0;
    logic          dco_clk = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   target = '0;
    logic [127:0]  coarse;
    logic [6:0]    code_idx;
    logic [15:0]   meas_count;
    logic          busy, done, lock;

    logic          dco_fast = 1'b0;
    logic          start_s = 1'b0;
    logic [7:0]    target_s = '0;
    logic [127:0]  coarse_s;
    logic [6:0]    code_s;
    logic [7:0]    meas_s;
    logic          busy_s, done_s, lock_s;

    int checks = 0;
    int errors = 0;

    dco_coarse_tuner dut (
        .clk(clk), .reset_(reset_), .dco_clk(dco_clk), .start(start),
        .target(target), .coarse(coarse), .code_idx(code_idx),
        .meas_count(meas_count), .busy(busy), .done(done), .lock(lock)
    );

    dco_coarse_tuner #(.CW(8)) dut_sat (
        .clk(clk), .reset_(reset_), .dco_clk(dco_fast), .start(start_s),
        .target(target_s), .coarse(coarse_s), .code_idx(code_s),
        .meas_count(meas_s), .busy(busy_s), .done(done_s), .lock(lock_s)
    );

    always #5 clk = ~clk;

    initial begin
        #0.25;
        forever begin
            dco_fast = ~dco_fast;
            #0.5;
        end
    end

    // Linear DCO stub: any 64 consecutive reference cycles at a fixed code hold
    // exactly 100+2*idx edges, placed clear of the reference edges.
    initial begin
        longint ccyc = 0;
        int n, k;
        forever begin
            @(posedge clk);
            #1;
            n = 100 + 2 * $countones(coarse);
            k = int'(((ccyc + 1) * n) / 64 - (ccyc * n) / 64);
            ccyc++;
            repeat (k) begin
                dco_clk = 1'b1; #0.6;
                dco_clk = 1'b0; #0.6;
            end
        end
    end

    task automatic acquire(input logic [15:0] tgt, input int pulse2,
                           output int done_at, output int ndone,
                           output logic busy1, output logic lock1,
                           output logic lock583, output logic lock584,
                           output logic busy_end);
        done_at = -1; ndone = 0;
        busy1 = 1'b0; lock1 = 1'b0; lock583 = 1'b0; lock584 = 1'b0; busy_end = 1'b1;
        @(negedge clk); target = tgt; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 600; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin busy1 = busy; lock1 = lock; end
            if (c == 583) lock583 = lock;
            if (c == 584) lock584 = lock;
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            if (c == pulse2) start = 1'b1;
            if (c == pulse2 + 1) start = 1'b0;
        end
        busy_end = busy;
    endtask

    task automatic test_reset();
        #1 reset_ = 1'b1;
        #1;
        checks++; if (coarse !== '0)     begin errors++; $display("FAIL reset_coarse got %h expected 0", coarse); end
        checks++; if (code_idx !== '0)   begin errors++; $display("FAIL reset_code got %0d expected 0", code_idx); end
        checks++; if (meas_count !== '0) begin errors++; $display("FAIL reset_meas got %0d expected 0", meas_count); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b expected 0", done); end
        checks++; if (lock !== 1'b0)     begin errors++; $display("FAIL reset_lock got %b expected 0", lock); end
        repeat (3) @(negedge clk);
        reset_ = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_search_200();
        int da, nd;
        logic b1, l1, l583, l584, be;
        logic [127:0] exp_c;
        acquire(16'd200, -10, da, nd, b1, l1, l583, l584, be);
        exp_c = (128'd1 << 50) - 128'd1;
        checks++; if (da !== 585)         begin errors++; $display("FAIL s200_done_cycle got %0d expected 585", da); end
        checks++; if (nd !== 1)           begin errors++; $display("FAIL s200_done_pulses got %0d expected 1", nd); end
        checks++; if (b1 !== 1'b1)        begin errors++; $display("FAIL s200_busy_c1 got %b expected 1", b1); end
        checks++; if (l583 !== 1'b0)      begin errors++; $display("FAIL s200_lock_c583 got %b expected 0", l583); end
        checks++; if (l584 !== 1'b1)      begin errors++; $display("FAIL s200_lock_c584 got %b expected 1", l584); end
        checks++; if (code_idx !== 7'd50) begin errors++; $display("FAIL s200_code got %0d expected 50", code_idx); end
        checks++; if (coarse !== exp_c)   begin errors++; $display("FAIL s200_coarse got %h expected %h", coarse, exp_c); end
        checks++; if (meas_count !== 16'd200) begin errors++; $display("FAIL s200_meas got %0d expected 200", meas_count); end
        checks++; if (lock !== 1'b1)      begin errors++; $display("FAIL s200_lock got %b expected 1", lock); end
        checks++; if (be !== 1'b0)        begin errors++; $display("FAIL s200_busy_end got %b expected 0", be); end
    endtask

    task automatic test_targets();
        logic [15:0] tg [4] = '{16'd0, 16'hFFFF, 16'd199, 16'd195};
        logic [6:0]  ec [4] = '{7'd0, 7'd127, 7'd49, 7'd47};
        logic [15:0] em [4] = '{16'd100, 16'd354, 16'd198, 16'd194};
        logic        el [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int da, nd;
        logic b1, l1, l583, l584, be;
        logic [127:0] exp_c;
        for (int i = 0; i < 4; i++) begin
            acquire(tg[i], -10, da, nd, b1, l1, l583, l584, be);
            exp_c = (128'd1 << ec[i]) - 128'd1;
            checks++; if (l1 !== 1'b0)        begin errors++; $display("FAIL t%0d_lock_cleared got %b expected 0", i, l1); end
            checks++; if (da !== 585)         begin errors++; $display("FAIL t%0d_done_cycle got %0d expected 585", i, da); end
            checks++; if (code_idx !== ec[i]) begin errors++; $display("FAIL t%0d_code got %0d expected %0d", i, code_idx, ec[i]); end
            checks++; if (coarse !== exp_c)   begin errors++; $display("FAIL t%0d_coarse got %h expected %h", i, coarse, exp_c); end
            checks++; if (meas_count !== em[i]) begin errors++; $display("FAIL t%0d_meas got %0d expected %0d", i, meas_count, em[i]); end
            checks++; if (lock !== el[i])     begin errors++; $display("FAIL t%0d_lock got %b expected %b", i, lock, el[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int da, nd;
        logic b1, l1, l583, l584, be;
        acquire(16'd200, 290, da, nd, b1, l1, l583, l584, be);
        checks++; if (da !== 585)         begin errors++; $display("FAIL b2b_done_cycle got %0d expected 585", da); end
        checks++; if (nd !== 1)           begin errors++; $display("FAIL b2b_done_pulses got %0d expected 1", nd); end
        checks++; if (code_idx !== 7'd50) begin errors++; $display("FAIL b2b_code got %0d expected 50", code_idx); end
        checks++; if (be !== 1'b0)        begin errors++; $display("FAIL b2b_busy_end got %b expected 0", be); end
    endtask

    task automatic test_reset_abort();
        int da, nd;
        logic b1, l1, l583, l584, be;
        @(negedge clk); target = 16'd200; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 170; c++) @(posedge clk);
        #2;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b expected 1", busy); end
        reset_ = 1'b1;
        #1;
        checks++; if (coarse !== '0)     begin errors++; $display("FAIL abort_coarse got %h expected 0", coarse); end
        checks++; if (code_idx !== '0)   begin errors++; $display("FAIL abort_code got %0d expected 0", code_idx); end
        checks++; if (meas_count !== '0) begin errors++; $display("FAIL abort_meas got %0d expected 0", meas_count); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL abort_busy got %b expected 0", busy); end
        checks++; if (lock !== 1'b0)     begin errors++; $display("FAIL abort_lock got %b expected 0", lock); end
        @(negedge clk); reset_ = 1'b0;
        repeat (2) @(negedge clk);
        acquire(16'd200, -10, da, nd, b1, l1, l583, l584, be);
        checks++; if (da !== 585)         begin errors++; $display("FAIL restart_done_cycle got %0d expected 585", da); end
        checks++; if (code_idx !== 7'd50) begin errors++; $display("FAIL restart_code got %0d expected 50", code_idx); end
        checks++; if (meas_count !== 16'd200) begin errors++; $display("FAIL restart_meas got %0d expected 200", meas_count); end
        checks++; if (lock !== 1'b1)      begin errors++; $display("FAIL restart_lock got %b expected 1", lock); end
    endtask

    task automatic test_saturation();
        int da = -1;
        logic [127:0] exp_c;
        exp_c = {1'b0, {127{1'b1}}};
        @(negedge clk); target_s = 8'd255; start_s = 1'b1;
        @(negedge clk); start_s = 1'b0;
        for (int c = 1; c <= 700; c++) begin
            @(posedge clk); #1;
            if (done_s && da < 0) da = c;
        end
        checks++; if (da !== 585)         begin errors++; $display("FAIL sat_done_cycle got %0d expected 585", da); end
        checks++; if (meas_s !== 8'd255)  begin errors++; $display("FAIL sat_meas got %0d expected 255", meas_s); end
        checks++; if (code_s !== 7'd127)  begin errors++; $display("FAIL sat_code got %0d expected 127", code_s); end
        checks++; if (coarse_s !== exp_c) begin errors++; $display("FAIL sat_coarse got %h expected %h", coarse_s, exp_c); end
        checks++; if (lock_s !== 1'b1)    begin errors++; $display("FAIL sat_lock got %b expected 1", lock_s); end
    endtask

    initial begin
        test_reset();
        test_search_200();
        test_targets();
        test_back_to_back();
        test_reset_abort();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
